// File: rtl/cell_histogram_scheduler_if.sv
// Row-histogram input stream and cell-histogram output stream of the
// cell histogram scheduler, bundled for connection to the design.
interface cell_histogram_scheduler_if #(
    parameter int BINS           = 10,
    parameter int ROW_BIN_WIDTH  = 11,
    parameter int CELL_BIN_WIDTH = 14,
    parameter int COL_WIDTH      = 7
);
    logic                              in_valid;
    logic                              in_ready;
    logic [BINS*ROW_BIN_WIDTH-1:0]     row_histogram;
    logic                              out_valid;
    logic                              out_ready;
    logic [BINS*CELL_BIN_WIDTH-1:0]    cell_histogram;
    logic [COL_WIDTH-1:0]              cell_col;
    logic                              band_last;

    // Upstream producer / downstream consumer side.
    modport master (
        output in_valid, row_histogram, out_ready,
        input  in_ready, out_valid, cell_histogram, cell_col, band_last
    );

    // Scheduler side.
    modport slave (
        input  in_valid, row_histogram, out_ready,
        output in_ready, out_valid, cell_histogram, cell_col, band_last
    );
endinterface

// File: rtl/cell_histogram_scheduler.sv
// Accumulates per-row histograms of each cell column into 8x8 cell
// histograms and presents each finished cell through a valid/ready stage.
module cell_histogram_scheduler #(
    parameter int CELLS_PER_ROW  = 80,
    parameter int ROWS_PER_CELL  = 8,
    parameter int BINS           = 10,
    parameter int ROW_BIN_WIDTH  = 11,
    parameter int CELL_BIN_WIDTH = 14,
    parameter int COL_WIDTH      = 7
) (
    input  logic                      clk,
    input  logic                      rst,
    cell_histogram_scheduler_if.slave bus
);
    localparam int ROW_WIDTH  = (ROWS_PER_CELL > 1) ? $clog2(ROWS_PER_CELL) : 1;
    localparam int ADDR_WIDTH = $clog2(CELLS_PER_ROW);
    localparam int HIST_WIDTH = BINS * CELL_BIN_WIDTH;

    localparam logic [COL_WIDTH-1:0] COL_LAST = COL_WIDTH'(CELLS_PER_ROW - 1);
    localparam logic [ROW_WIDTH-1:0] ROW_LAST = ROW_WIDTH'(ROWS_PER_CELL - 1);

    typedef enum logic {
        S_EMPTY,
        S_FULL
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [COL_WIDTH-1:0]    col;
    logic [ROW_WIDTH-1:0]    row;
    logic [ADDR_WIDTH-1:0]   addr;
    logic                    last_row;
    logic                    accept;
    logic [HIST_WIDTH-1:0]   sum;
    logic [HIST_WIDTH-1:0]   hist_reg;
    logic [COL_WIDTH-1:0]    col_reg;
    logic                    band_last_reg;

    // Partial sums of the current band, one entry per cell column.
    logic [HIST_WIDTH-1:0]   partial [CELLS_PER_ROW];

    assign addr     = col[ADDR_WIDTH-1:0];
    assign last_row = (row == ROW_LAST);
    assign accept   = bus.in_valid && bus.in_ready;

    assign bus.cell_histogram = hist_reg;
    assign bus.cell_col       = col_reg;
    assign bus.band_last      = band_last_reg;

    // Per-bin sum: row 0 starts fresh, so stale buffer data of the previous
    // band (or of an abandoned band after reset) never leaks in.
    always_comb begin
        sum = '0;
        for (int unsigned k = 0; k < BINS; k++) begin
            sum[k*CELL_BIN_WIDTH +: CELL_BIN_WIDTH] =
                ((row == '0) ? '0 : partial[addr][k*CELL_BIN_WIDTH +: CELL_BIN_WIDTH])
                + CELL_BIN_WIDTH'(bus.row_histogram[k*ROW_BIN_WIDTH +: ROW_BIN_WIDTH]);
        end
    end

    // Column/row position of the next beat within the band.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (col == COL_LAST) begin
                col <= '0;
                row <= row + ROW_WIDTH'(1);
            end else begin
                col <= col + COL_WIDTH'(1);
            end
        end
    end

    // Partial-sum storage; the last row goes straight to the output register.
    always_ff @(posedge clk) begin
        if (accept && !last_row) begin
            partial[addr] <= sum;
        end
    end

    // Output register, loaded by every accepted last-row beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_reg      <= '0;
            col_reg       <= '0;
            band_last_reg <= 1'b0;
        end else if (accept && last_row) begin
            hist_reg      <= sum;
            col_reg       <= col;
            band_last_reg <= (col == COL_LAST);
        end
    end

    // Output FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Output FSM next state and handshake outputs.
    always_comb begin
        state_next    = state;
        bus.out_valid = 1'b0;
        bus.in_ready  = 1'b1;
        case (state)
            S_EMPTY: begin
                if (accept && last_row) begin
                    state_next = S_FULL;
                end
            end
            S_FULL: begin
                bus.out_valid = 1'b1;
                // Only a last-row beat needs the output register; it may
                // proceed when the held cell is consumed in the same cycle.
                bus.in_ready  = !(last_row && !bus.out_ready);
                if (accept && last_row) begin
                    state_next = S_FULL;
                end else if (bus.out_ready) begin
                    state_next = S_EMPTY;
                end
            end
            default: begin
                state_next = S_EMPTY;
            end
        endcase
    end
endmodule

// File: tb/tb_cell_histogram_scheduler.sv
// Scoreboard bench for cell_histogram_scheduler: one instance with two
// cell columns for directed tests, one with three for randomised traffic.
module tb_cell_histogram_scheduler;
    localparam int BINS = 10;
    localparam int RBW  = 11;
    localparam int CBW  = 14;
    localparam int CW   = 7;
    localparam int R    = 8;
    localparam int RW   = BINS * RBW;
    localparam int HW   = BINS * CBW;

    typedef struct {
        logic [HW-1:0] h;
        int            col;
        logic          last;
    } cell_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cell_histogram_scheduler_if #(.BINS(BINS), .ROW_BIN_WIDTH(RBW), .CELL_BIN_WIDTH(CBW), .COL_WIDTH(CW)) bus0 ();
    cell_histogram_scheduler_if #(.BINS(BINS), .ROW_BIN_WIDTH(RBW), .CELL_BIN_WIDTH(CBW), .COL_WIDTH(CW)) bus1 ();

    cell_histogram_scheduler #(
        .CELLS_PER_ROW(2), .ROWS_PER_CELL(R), .BINS(BINS),
        .ROW_BIN_WIDTH(RBW), .CELL_BIN_WIDTH(CBW), .COL_WIDTH(CW)
    ) u_dut2 (.clk(clk), .rst(rst), .bus(bus0));

    cell_histogram_scheduler #(
        .CELLS_PER_ROW(3), .ROWS_PER_CELL(R), .BINS(BINS),
        .ROW_BIN_WIDTH(RBW), .CELL_BIN_WIDTH(CBW), .COL_WIDTH(CW)
    ) u_dut3 (.clk(clk), .rst(rst), .bus(bus1));

    logic          drv_valid [2];
    logic          drv_ordy  [2];
    logic [RW-1:0] drv_hist  [2];

    assign bus0.in_valid      = drv_valid[0];
    assign bus0.out_ready     = drv_ordy[0];
    assign bus0.row_histogram = drv_hist[0];
    assign bus1.in_valid      = drv_valid[1];
    assign bus1.out_ready     = drv_ordy[1];
    assign bus1.row_histogram = drv_hist[1];

    logic          obs_rdy  [2];
    logic          obs_ov   [2];
    logic          obs_last [2];
    logic [HW-1:0] obs_hist [2];
    logic [CW-1:0] obs_col  [2];

    assign obs_rdy[0]  = bus0.in_ready;
    assign obs_ov[0]   = bus0.out_valid;
    assign obs_last[0] = bus0.band_last;
    assign obs_hist[0] = bus0.cell_histogram;
    assign obs_col[0]  = bus0.cell_col;
    assign obs_rdy[1]  = bus1.in_ready;
    assign obs_ov[1]   = bus1.out_valid;
    assign obs_last[1] = bus1.band_last;
    assign obs_hist[1] = bus1.cell_histogram;
    assign obs_col[1]  = bus1.cell_col;

    int    n_cmp = 0;
    int    n_err = 0;

    int    ncells [2] = '{2, 3};
    int    m_col  [2];
    int    m_row  [2];
    logic  m_full [2];
    logic  m_acc  [2];
    int    m_buf  [2][3][BINS];
    int    n_out  [2];
    cell_t q0[$];
    cell_t q1[$];

    task automatic check_eq(input string tag, input logic [HW-1:0] got, input logic [HW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [RW-1:0] fill(input int val);
        logic [RW-1:0] h;
        h = '0;
        for (int k = 0; k < BINS; k++) h[k*RBW +: RBW] = RBW'(val);
        return h;
    endfunction

    function automatic logic [RW-1:0] one_bin(input int i, input int val);
        logic [RW-1:0] h;
        h = '0;
        h[(i % 9)*RBW +: RBW] = RBW'(val);
        h[9*RBW +: RBW]       = RBW'(val);
        return h;
    endfunction

    function automatic logic [RW-1:0] rand_hist();
        logic [RW-1:0] h;
        for (int k = 0; k < BINS; k++) h[k*RBW +: RBW] = RBW'($urandom_range(0, 2040));
        return h;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_col[d]  = 0;
            m_row[d]  = 0;
            m_full[d] = 1'b0;
            m_acc[d]  = 1'b0;
        end
        q0.delete();
        q1.delete();
    endtask

    // Compare one DUT against the model for the edge about to come, then
    // advance the model past that edge.
    task automatic model_step(input int d);
        logic  exp_rdy;
        cell_t c;
        int    qs;
        int    s;
        exp_rdy = !(m_full[d] && (m_row[d] == R - 1) && !drv_ordy[d]);
        check_eq("in_ready", HW'(obs_rdy[d]), HW'(exp_rdy));
        check_eq("out_valid", HW'(obs_ov[d]), HW'(m_full[d]));
        if (m_full[d]) begin
            qs = (d == 0) ? q0.size() : q1.size();
            if (qs == 0) begin
                check_eq("queue_empty", HW'(qs), HW'(1));
            end else begin
                c = (d == 0) ? q0[0] : q1[0];
                check_eq("cell_histogram", obs_hist[d], c.h);
                check_eq("cell_col", HW'(obs_col[d]), HW'(c.col));
                check_eq("band_last", HW'(obs_last[d]), HW'(c.last));
                if (drv_ordy[d]) begin
                    if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
                    n_out[d]++;
                end
            end
        end
        m_acc[d] = drv_valid[d] && exp_rdy;
        if (m_acc[d] && (m_row[d] == R - 1)) begin
            m_full[d] = 1'b1;
        end else if (m_full[d] && drv_ordy[d]) begin
            m_full[d] = 1'b0;
        end
        if (m_acc[d]) begin
            c.h = '0;
            for (int k = 0; k < BINS; k++) begin
                s = ((m_row[d] == 0) ? 0 : m_buf[d][m_col[d]][k]) + int'(drv_hist[d][k*RBW +: RBW]);
                m_buf[d][m_col[d]][k] = s;
                c.h[k*CBW +: CBW] = CBW'(s);
            end
            if (m_row[d] == R - 1) begin
                c.col  = m_col[d];
                c.last = (m_col[d] == ncells[d] - 1);
                if (d == 0) q0.push_back(c); else q1.push_back(c);
            end
            if (m_col[d] == ncells[d] - 1) begin
                m_col[d] = 0;
                m_row[d] = (m_row[d] + 1) % R;
            end else begin
                m_col[d]++;
            end
        end
    endtask

    task automatic cycle(input int d, input logic v, input logic [RW-1:0] h, input logic o);
        @(negedge clk);
        for (int e = 0; e < 2; e++) begin
            drv_valid[e] = (e == d) ? v : 1'b0;
            drv_hist[e]  = (e == d) ? h : '0;
            drv_ordy[e]  = (e == d) ? o : 1'b1;
        end
        #1;
        model_step(0);
        model_step(1);
    endtask

    task automatic send(input int d, input logic [RW-1:0] h, input logic o);
        for (int n = 0; n < 50; n++) begin
            cycle(d, 1'b1, h, o);
            if (m_acc[d]) return;
        end
        check_eq("send_timeout", HW'(0), HW'(1));
    endtask

    task automatic drain();
        for (int n = 0; n < 20; n++) begin
            if (q0.size() == 0 && q1.size() == 0) break;
            cycle(0, 1'b0, '0, 1'b1);
        end
        check_eq("drain_left", HW'(q0.size() + q1.size()), HW'(0));
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int e = 0; e < 2; e++) begin
            drv_valid[e] = 1'b0;
            drv_ordy[e]  = 1'b0;
            drv_hist[e]  = fill(7);
        end
        for (int n = 0; n < 2; n++) begin
            #1;
            for (int e = 0; e < 2; e++) begin
                check_eq("rst_in_ready", HW'(obs_rdy[e]), HW'(1));
                check_eq("rst_out_valid", HW'(obs_ov[e]), HW'(0));
                check_eq("rst_cell_histogram", obs_hist[e], HW'(0));
                check_eq("rst_cell_col", HW'(obs_col[e]), HW'(0));
                check_eq("rst_band_last", HW'(obs_last[e]), HW'(0));
            end
            @(negedge clk);
        end
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [RW-1:0] hcur;
        int            idx;
        model_reset();
        apply_reset();

        // Abandon a band mid-way, then a clean band of ones.
        for (int i = 0; i < 5; i++) send(0, fill(3), 1'b1);
        apply_reset();
        n_out[0] = 0;
        for (int i = 0; i < 16; i++) send(0, fill(1), 1'b1);
        drain();
        check_eq("reset_band_outputs", HW'(n_out[0]), HW'(2));

        // Accumulation of full-scale row bins onto rotating bins.
        n_out[0] = 0;
        for (int i = 0; i < 16; i++) send(0, one_bin(i, 2040), 1'b1);
        drain();
        check_eq("accum_outputs", HW'(n_out[0]), HW'(2));

        // Two back-to-back bands.
        n_out[0] = 0;
        for (int i = 0; i < 32; i++) send(0, fill(5), 1'b1);
        drain();
        check_eq("band_outputs", HW'(n_out[0]), HW'(4));

        // Backpressure and same-cycle consume/reload.
        n_out[0] = 0;
        for (int i = 0; i < 15; i++) send(0, fill(i + 1), 1'b1);
        repeat (3) cycle(0, 1'b1, fill(16), 1'b0);
        send(0, fill(16), 1'b1);
        for (int i = 0; i < 14; i++) send(0, fill(20 + i), 1'b0);
        repeat (4) cycle(0, 1'b1, fill(40), 1'b0);
        send(0, fill(40), 1'b1);
        send(0, fill(41), 1'b1);
        drain();
        check_eq("bp_outputs", HW'(n_out[0]), HW'(4));

        // Random gaps on both sides over four bands of three columns.
        n_out[1] = 0;
        idx      = 0;
        hcur     = rand_hist();
        for (int n = 0; n < 3000 && idx < 4*3*R; n++) begin
            cycle(1, ($urandom_range(0, 3) != 0), hcur, ($urandom_range(0, 2) != 0));
            if (m_acc[1]) begin
                idx++;
                hcur = rand_hist();
            end
        end
        check_eq("rand_beats", HW'(idx), HW'(4*3*R));
        drain();
        check_eq("rand_outputs", HW'(n_out[1]), HW'(12));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
